// File: rtl/dp_sink_aux_responder.sv
// DisplayPort sink AUX reply engine: byte-per-clock native request receive, DPCD
// byte array, delayed reply burst, DEFER injection and HPD / IRQ pulse generation.
module dp_sink_aux_responder #(
  parameter int AUX_ADDRESS_WIDTH = 20,
  parameter int AUX_DATA_WIDTH    = 8,
  parameter int DPCD_DEPTH        = 256,
  parameter int MAX_BURST         = 16,
  parameter int REPLY_DELAY       = 4,
  parameter int IRQ_PULSE_CYCLES  = 500
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AUX_DATA_WIDTH-1:0] aux_in_data,
  input  logic                      aux_start_stop,
  output logic [AUX_DATA_WIDTH-1:0] aux_out_data,
  output logic                      phy_start_stop,
  output logic                      aux_oe,
  input  logic                      hpd_connect,
  input  logic                      hpd_irq_req,
  input  logic [3:0]                defer_count,
  output logic                      hpd_signal,
  output logic                      busy,
  output logic [7:0]                err_cnt
);
  // state   | meaning
  // A_IDLE  | waiting for a request byte
  // A_RX    | collecting request bytes
  // A_CHECK | pick reply code, commit write data
  // A_WAIT  | reply turnaround delay
  // A_TX    | driving reply burst
  // H_DISC  | sink unplugged, HPD low
  // H_CONN  | plugged, HPD high
  // H_IRQ   | HPD low for the IRQ pulse
  localparam int RX_BYTES = 4 + MAX_BURST;
  localparam int CW = $clog2(RX_BYTES + 1);
  localparam int BW = $clog2(RX_BYTES);
  localparam int DW = $clog2(DPCD_DEPTH);
  localparam int WW = $clog2(REPLY_DELAY + 1);
  localparam int TW = $clog2(MAX_BURST + 2);
  localparam int IW = $clog2(IRQ_PULSE_CYCLES + 1);

  typedef enum logic [2:0] {A_IDLE, A_RX, A_CHECK, A_WAIT, A_TX} aux_state_t;
  typedef enum logic [1:0] {H_DISC, H_CONN, H_IRQ} hpd_state_t;

  logic [AUX_DATA_WIDTH-1:0]    dpcd_q   [DPCD_DEPTH];
  logic [AUX_DATA_WIDTH-1:0]    rx_buf_q [RX_BYTES];
  aux_state_t                   aux_state_q, aux_state_d;
  hpd_state_t                   hpd_state_q, hpd_state_d;
  logic [CW-1:0]                rx_cnt_q, rx_cnt_d;
  logic                         ovf_q, ovf_d;
  logic [AUX_ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [AUX_DATA_WIDTH-1:0]    len_q, len_d;
  logic [AUX_DATA_WIDTH-1:0]    code_q, code_d;
  logic                         rd_data_q, rd_data_d;
  logic [3:0]                   defer_cnt_q, defer_cnt_d;
  logic [WW-1:0]                wait_cnt_q, wait_cnt_d;
  logic [TW-1:0]                tx_idx_q, tx_idx_d;
  logic [IW-1:0]                irq_cnt_q, irq_cnt_d;
  logic [7:0]                   err_cnt_q, err_cnt_d;

  logic                         buf_wr, commit, err_inc, link_up, is_rd, is_wr, bad_req, tx_active;
  logic [BW-1:0]                buf_idx;
  logic [3:0]                   hdr_cmd;
  logic [AUX_ADDRESS_WIDTH-1:0] hdr_addr;
  logic [AUX_DATA_WIDTH-1:0]    hdr_len;
  logic [TW-1:0]                tx_last;
  logic [DW-1:0]                rd_idx;

  assign hdr_cmd  = rx_buf_q[0][AUX_DATA_WIDTH-1 -: 4];
  assign hdr_addr = AUX_ADDRESS_WIDTH'({rx_buf_q[0][3:0], rx_buf_q[1], rx_buf_q[2]});
  assign hdr_len  = rx_buf_q[3];
  assign is_rd    = (hdr_cmd == 4'b1001);
  assign is_wr    = (hdr_cmd == 4'b1000);
  assign bad_req  = !(is_rd || is_wr) || (int'(hdr_len) >= MAX_BURST)
                    || (int'(hdr_addr) + int'(hdr_len) >= DPCD_DEPTH) || ovf_q
                    || (is_wr && (int'(rx_cnt_q) != int'(hdr_len) + 5));
  assign link_up  = hpd_connect && (hpd_state_q != H_DISC);

  assign tx_active      = (aux_state_q == A_TX);
  assign tx_last        = rd_data_q ? TW'(int'(len_q) + 1) : '0;
  assign rd_idx         = DW'(int'(addr_q) + int'(tx_idx_q) - 1);
  assign aux_oe         = tx_active;
  assign phy_start_stop = tx_active;
  assign aux_out_data   = !tx_active ? '0 : ((tx_idx_q == '0) ? code_q : dpcd_q[rd_idx]);
  assign busy           = (aux_state_q != A_IDLE);
  assign err_cnt        = err_cnt_q;
  assign hpd_signal     = (hpd_state_q == H_CONN);

  always_comb begin
    aux_state_d = aux_state_q;
    rx_cnt_d    = rx_cnt_q;
    ovf_d       = ovf_q;
    addr_d      = addr_q;
    len_d       = len_q;
    code_d      = code_q;
    rd_data_d   = rd_data_q;
    defer_cnt_d = defer_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    tx_idx_d    = tx_idx_q;
    err_cnt_d   = err_cnt_q;
    buf_wr      = 1'b0;
    buf_idx     = '0;
    commit      = 1'b0;
    err_inc     = 1'b0;
    if (!link_up) begin
      aux_state_d = A_IDLE;
    end else begin
      case (aux_state_q)
        A_IDLE: if (aux_start_stop) begin
          buf_wr      = 1'b1;
          rx_cnt_d    = CW'(1);
          ovf_d       = 1'b0;
          aux_state_d = A_RX;
        end
        A_RX: begin
          if (aux_start_stop) begin
            if (int'(rx_cnt_q) < RX_BYTES) begin
              buf_wr   = 1'b1;
              buf_idx  = BW'(rx_cnt_q);
              rx_cnt_d = rx_cnt_q + 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end else if (int'(rx_cnt_q) < 4) begin
            err_inc     = 1'b1;
            aux_state_d = A_IDLE;
          end else begin
            aux_state_d = A_CHECK;
          end
        end
        A_CHECK: begin
          err_inc   = aux_start_stop;
          addr_d    = hdr_addr;
          len_d     = hdr_len;
          rd_data_d = 1'b0;
          if (defer_cnt_q < defer_count) begin
            code_d      = AUX_DATA_WIDTH'(8'h20);
            defer_cnt_d = defer_cnt_q + 4'd1;
          end else if (bad_req) begin
            code_d = AUX_DATA_WIDTH'(8'h10);
          end else begin
            code_d      = '0;
            defer_cnt_d = '0;
            rd_data_d   = is_rd;
            commit      = is_wr;
          end
          wait_cnt_d  = WW'(REPLY_DELAY - 1);
          tx_idx_d    = '0;
          aux_state_d = A_WAIT;
        end
        A_WAIT: begin
          err_inc = aux_start_stop;
          if (wait_cnt_q == '0) aux_state_d = A_TX;
          else                  wait_cnt_d  = wait_cnt_q - 1'b1;
        end
        A_TX: begin
          err_inc = aux_start_stop;
          if (tx_idx_q == tx_last) aux_state_d = A_IDLE;
          else                     tx_idx_d    = tx_idx_q + 1'b1;
        end
        default: aux_state_d = A_IDLE;
      endcase
    end
    if (err_inc && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_comb begin
    hpd_state_d = hpd_state_q;
    irq_cnt_d   = irq_cnt_q;
    if (!hpd_connect) begin
      hpd_state_d = H_DISC;
    end else begin
      case (hpd_state_q)
        H_DISC: hpd_state_d = H_CONN;
        H_CONN: if (hpd_irq_req) begin
          hpd_state_d = H_IRQ;
          irq_cnt_d   = IW'(IRQ_PULSE_CYCLES - 1);
        end
        H_IRQ: begin
          if (irq_cnt_q == '0) hpd_state_d = H_CONN;
          else                 irq_cnt_d   = irq_cnt_q - 1'b1;
        end
        default: hpd_state_d = H_DISC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aux_state_q <= A_IDLE;
      hpd_state_q <= H_DISC;
      rx_cnt_q    <= '0;
      ovf_q       <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      code_q      <= '0;
      rd_data_q   <= 1'b0;
      defer_cnt_q <= '0;
      wait_cnt_q  <= '0;
      tx_idx_q    <= '0;
      irq_cnt_q   <= '0;
      err_cnt_q   <= '0;
      for (int i = 0; i < DPCD_DEPTH; i++) dpcd_q[i] <= '0;
      for (int i = 0; i < RX_BYTES; i++) rx_buf_q[i] <= '0;
    end else begin
      aux_state_q <= aux_state_d;
      hpd_state_q <= hpd_state_d;
      rx_cnt_q    <= rx_cnt_d;
      ovf_q       <= ovf_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      code_q      <= code_d;
      rd_data_q   <= rd_data_d;
      defer_cnt_q <= defer_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      tx_idx_q    <= tx_idx_d;
      irq_cnt_q   <= irq_cnt_d;
      err_cnt_q   <= err_cnt_d;
      if (buf_wr) rx_buf_q[buf_idx] <= aux_in_data;
      // Whole-burst commit in one cycle, so a reset can never leave a partial write.
      if (commit)
        for (int i = 0; i < MAX_BURST; i++)
          if (i <= int'(hdr_len)) dpcd_q[DW'(int'(hdr_addr) + i)] <= rx_buf_q[BW'(4 + i)];
    end
  end
endmodule

// File: tb/tb_dp_sink_aux_responder.sv
// Self-checking bench for dp_sink_aux_responder: vector table plus reply scoreboard.
module tb_dp_sink_aux_responder;
  localparam int REPLY_DELAY = 4;
  localparam int LAT = 1 + REPLY_DELAY + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] aux_in_data;
  logic       aux_start_stop;
  logic [7:0] aux_out_data;
  logic       phy_start_stop;
  logic       aux_oe;
  logic       hpd_connect;
  logic       hpd_irq_req;
  logic [3:0] defer_count;
  logic       hpd_signal;
  logic       busy;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  dp_sink_aux_responder dut (
    .clk(clk), .rst(rst), .aux_in_data(aux_in_data), .aux_start_stop(aux_start_stop),
    .aux_out_data(aux_out_data), .phy_start_stop(phy_start_stop), .aux_oe(aux_oe),
    .hpd_connect(hpd_connect), .hpd_irq_req(hpd_irq_req), .defer_count(defer_count),
    .hpd_signal(hpd_signal), .busy(busy), .err_cnt(err_cnt)
  );

  typedef struct packed {
    logic [3:0]  cmd;
    logic [19:0] addr;
    logic [7:0]  len;
    logic [7:0]  ndata;
    logic [7:0]  base;
    logic [7:0]  code;
  } vec_t;

  int         n_vec = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         fall_cyc = 0;
  int         first_cyc = -1;
  int         burst = 0;
  int         last_burst = 0;
  int         oe_bad = 0;
  logic       prev_phy = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] req_q[$];
  logic [7:0] model[256];
  vec_t       vecs[13];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (phy_start_stop) begin
      if (!prev_phy) begin
        first_cyc = cyc;
        burst = 0;
      end
      burst++;
      if (exp_q.size() == 0) chk("unexpected_reply_byte", int'(aux_out_data), -1);
      else                   chk("reply_byte", int'(aux_out_data), int'(exp_q.pop_front()));
    end else if (prev_phy) begin
      last_burst = burst;
    end
    if (aux_oe !== phy_start_stop || (!phy_start_stop && aux_out_data !== 8'h00)) oe_bad++;
    prev_phy = phy_start_stop;
  end

  task automatic send_req();
    foreach (req_q[i]) begin
      @(posedge clk); #1;
      aux_start_stop = 1'b1;
      aux_in_data    = req_q[i];
    end
    @(posedge clk); #1;
    aux_start_stop = 1'b0;
    aux_in_data    = 8'h00;
    fall_cyc       = cyc;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (!busy) break;
    end
    if (k == 200) chk("idle_timeout", 1, 0);
  endtask

  task automatic build_req(input vec_t v);
    req_q.delete();
    req_q.push_back({v.cmd, v.addr[19:16]});
    req_q.push_back(v.addr[15:8]);
    req_q.push_back(v.addr[7:0]);
    req_q.push_back(v.len);
    for (int i = 0; i < int'(v.ndata); i++) req_q.push_back(8'(int'(v.base) + i * 17));
  endtask

  task automatic apply_vec(input vec_t v);
    int exp_burst;
    build_req(v);
    exp_q.push_back(v.code);
    exp_burst = 1;
    if (v.code == 8'h00) begin
      for (int i = 0; i <= int'(v.len); i++) begin
        if (v.cmd == 4'h9) exp_q.push_back(model[8'(int'(v.addr) + i)]);
        else if (v.cmd == 4'h8) model[8'(int'(v.addr) + i)] = 8'(int'(v.base) + i * 17);
      end
      if (v.cmd == 4'h9) exp_burst = int'(v.len) + 2;
    end
    first_cyc = -1;
    send_req();
    wait_idle();
    chk("queue_drained", exp_q.size(), 0);
    chk("first_byte_latency", first_cyc - fall_cyc, LAT);
    chk("burst_length", last_burst, exp_burst);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int k, low_cnt;
    logic irq_clr;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    vecs[0]  = '{4'h8, 20'h00010, 8'd3,  8'd4,  8'hA1, 8'h00};
    vecs[1]  = '{4'h9, 20'h00010, 8'd3,  8'd0,  8'h00, 8'h00};
    vecs[2]  = '{4'h9, 20'h000FE, 8'd3,  8'd0,  8'h00, 8'h10};
    vecs[3]  = '{4'h8, 20'h00020, 8'd16, 8'd17, 8'h55, 8'h10};
    vecs[4]  = '{4'h9, 20'h00020, 8'd15, 8'd0,  8'h00, 8'h00};
    vecs[5]  = '{4'h8, 20'h000F0, 8'd15, 8'd16, 8'h30, 8'h00};
    vecs[6]  = '{4'h9, 20'h000F0, 8'd15, 8'd0,  8'h00, 8'h00};
    vecs[7]  = '{4'h9, 20'h000FF, 8'd0,  8'd0,  8'h00, 8'h00};
    vecs[8]  = '{4'h4, 20'h00010, 8'd0,  8'd0,  8'h00, 8'h10};
    vecs[9]  = '{4'h8, 20'h00050, 8'd3,  8'd2,  8'h77, 8'h10};
    vecs[10] = '{4'h8, 20'h00050, 8'd3,  8'd5,  8'h66, 8'h10};
    vecs[11] = '{4'h9, 20'h00050, 8'd16, 8'd0,  8'h00, 8'h10};
    vecs[12] = '{4'h9, 20'h00050, 8'd3,  8'd0,  8'h00, 8'h00};

    rst = 1'b1; aux_in_data = 8'h00; aux_start_stop = 1'b0; hpd_connect = 1'b0;
    hpd_irq_req = 1'b0; defer_count = 4'd0;
    #1;
    chk("reset_outputs", int'({aux_out_data, phy_start_stop, aux_oe, hpd_signal, busy, err_cnt}), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Requests while unplugged are silently ignored.
    build_req('{4'h9, 20'h00010, 8'd0, 8'd0, 8'h00, 8'h00});
    send_req();
    wait_idle();
    chk("disc_busy", int'(busy), 0);
    chk("disc_err_cnt", int'(err_cnt), 0);
    chk("disc_hpd", int'(hpd_signal), 0);

    hpd_connect = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("connect_hpd", int'(hpd_signal), 1);

    for (int i = 0; i < 13; i++) apply_vec(vecs[i]);

    defer_count = 4'd2;
    apply_vec('{4'h9, 20'h00000, 8'd0, 8'd0, 8'h00, 8'h20});
    apply_vec('{4'h9, 20'h00000, 8'd0, 8'd0, 8'h00, 8'h20});
    apply_vec('{4'h9, 20'h00000, 8'd0, 8'd0, 8'h00, 8'h00});
    defer_count = 4'd0;

    chk("err_before", int'(err_cnt), 0);
    req_q.delete(); req_q.push_back(8'h90); req_q.push_back(8'h00);
    send_req();
    wait_idle();
    chk("short_req_err", int'(err_cnt), 1);
    chk("short_req_noreply", exp_q.size(), 0);

    build_req('{4'h9, 20'h00010, 8'd0, 8'd0, 8'h00, 8'h00});
    exp_q.push_back(8'h00); exp_q.push_back(model[8'h10]);
    send_req();
    @(posedge clk); @(posedge clk); #1 aux_start_stop = 1'b1;
    repeat (3) @(posedge clk);
    #1 aux_start_stop = 1'b0;
    wait_idle();
    chk("wait_hold_err", int'(err_cnt), 4);
    chk("wait_hold_reply", exp_q.size(), 0);

    @(posedge clk); #1 hpd_irq_req = 1'b1;
    @(posedge clk); #1 hpd_irq_req = 1'b0;
    low_cnt = 0; irq_clr = 1'b0;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (irq_clr) begin hpd_irq_req = 1'b0; irq_clr = 1'b0; end
      if (hpd_signal) break;
      low_cnt++;
      if (low_cnt == 200) begin hpd_irq_req = 1'b1; irq_clr = 1'b1; end
    end
    chk("irq_low_cycles", low_cnt, 500);
    repeat (3) @(negedge clk);
    chk("irq_hpd_back_high", int'(hpd_signal), 1);

    build_req('{4'h9, 20'h000F0, 8'd7, 8'd0, 8'h00, 8'h00});
    exp_q.push_back(8'h00);
    for (int i = 0; i < 8; i++) exp_q.push_back(model[8'hF0 + 8'(i)]);
    send_req();
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (phy_start_stop) break;
    end
    if (k == 100) chk("burst_start_timeout", 0, 1);
    @(negedge clk); @(negedge clk);
    #1 hpd_connect = 1'b0;
    @(negedge clk);
    chk("cut_aux_oe", int'(aux_oe), 0);
    chk("cut_phy", int'(phy_start_stop), 0);
    chk("cut_busy", int'(busy), 0);
    chk("cut_hpd", int'(hpd_signal), 0);
    chk("cut_remaining", exp_q.size(), 6);
    exp_q.delete();
    #1 hpd_connect = 1'b1;
    repeat (3) @(posedge clk);
    apply_vec('{4'h9, 20'h000F0, 8'd3, 8'd0, 8'h00, 8'h00});

    req_q.delete();
    req_q = '{8'h80, 8'h00, 8'h60, 8'h03, 8'h11, 8'h22};
    foreach (req_q[i]) begin
      @(posedge clk); #1;
      aux_start_stop = 1'b1;
      aux_in_data    = req_q[i];
    end
    #3 rst = 1'b1;
    #1;
    chk("rst_mid_outputs", int'({aux_out_data, phy_start_stop, aux_oe, hpd_signal, busy}), 0);
    chk("rst_mid_err_cnt", int'(err_cnt), 0);
    aux_start_stop = 1'b0; aux_in_data = 8'h00;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    apply_vec('{4'h9, 20'h00010, 8'd3, 8'd0, 8'h00, 8'h00});
    apply_vec('{4'h9, 20'h000F0, 8'd15, 8'd0, 8'h00, 8'h00});

    chk("oe_phy_data_consistency", oe_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/dp_sink_aux_responder.md
Name: dp_sink_aux_responder

Overview:
- Synthesizable DisplayPort sink-side AUX reply engine with HPD generator; the RTL counterpart of the sink bench driver.
- Receives native AUX requests byte-per-clock, serves them from an internal DPCD byte array and replies byte-per-clock.
- Generalised over address/data width, DPCD depth, burst length and reply latency.
- Adds programmable DEFER injection and HPD IRQ pulse generation.

Parameters:
AUX_ADDRESS_WIDTH, 20, request address width (header carries 20 bits)
AUX_DATA_WIDTH, 8, AUX byte width
DPCD_DEPTH, 256, DPCD bytes at addresses 0..DPCD_DEPTH-1
MAX_BURST, 16, max bytes per request (LEN+1)
REPLY_DELAY, 4, idle cycles between CHECK and the first reply byte (>=1)
IRQ_PULSE_CYCLES, 500, HPD low duration for an IRQ pulse

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
aux_in_data  in  AUX_DATA_WIDTH  request byte from source
aux_start_stop  in  1  high = aux_in_data valid; falling edge ends request
aux_out_data  out  AUX_DATA_WIDTH  reply byte
phy_start_stop  out  1  high = aux_out_data valid
aux_oe  out  1  sink drives AUX (high for whole reply burst)
hpd_connect  in  1  sink plugged
hpd_irq_req  in  1  one-cycle IRQ pulse request
defer_count  in  4  DEFER replies to issue before serving a request
hpd_signal  out  1  HPD line
busy  out  1  AUX FSM not IDLE
err_cnt  out  8  saturating protocol-error counter

Behaviour:
- Reset: all outputs 0, DPCD array 0, FSMs IDLE/DISCONNECTED, defer counter 0.
- Request: B0={CMD[3:0],ADDR[19:16]}, B1=ADDR[15:8], B2=ADDR[7:0], B3=LEN (bytes=LEN+1), then write data.
- CMD 4'b1000 = native write, 4'b1001 = native read; any other CMD -> NACK.
- AUX FSM: IDLE -> RX on aux_start_stop=1, capturing that byte.
- RX: one byte per high cycle. First low cycle -> CHECK. Bytes beyond 4+MAX_BURST are discarded and flag the request as overflow.
- Fewer than 4 bytes at the end of RX: drop with no reply, err_cnt++, return to IDLE.
- CHECK (1 cycle) picks the reply code, first matching rule:
  - defer_cnt_q < defer_count -> DEFER 0x20, defer_cnt_q++.
  - Bad CMD, LEN+1 > MAX_BURST, ADDR+LEN >= DPCD_DEPTH, overflow, or write data count != LEN+1 -> NACK 0x10.
  - Otherwise ACK 0x00, defer_cnt_q cleared.
- Write ACK: the RX buffer is committed to DPCD in the CHECK cycle, all bytes or none.
- WAIT: REPLY_DELAY cycles, then TX.
- TX: aux_oe=1 and phy_start_stop=1 on consecutive cycles. Byte0 = reply code; read ACK adds LEN+1 data bytes from DPCD[ADDR..ADDR+LEN].
- After TX, aux_oe and phy_start_stop drop in the same cycle and the FSM returns to IDLE.
- Latency: first reply byte on cycle 1+REPLY_DELAY+1 after the first low cycle of aux_start_stop.
- aux_start_stop=1 during CHECK/WAIT/TX: ignored, err_cnt++ per high cycle. err_cnt saturates at 255.
- aux_out_data is 0 whenever phy_start_stop=0.
- HPD FSM, states DISCONNECTED / CONNECTED / IRQ_LOW:
  - hpd_connect=1 -> CONNECTED, hpd_signal=1.
  - hpd_irq_req in CONNECTED -> IRQ_LOW, hpd_signal=0 for exactly IRQ_PULSE_CYCLES cycles, then CONNECTED.
  - hpd_irq_req while in IRQ_LOW is ignored.
- hpd_connect=0 in any state -> DISCONNECTED next cycle, hpd_signal=0. AUX FSM forced to IDLE, aux_oe/phy_start_stop 0, partial request discarded, DPCD retained.
- While DISCONNECTED, aux_start_stop is ignored and not counted.
- Async rst mid-transaction: immediate return to reset state; no partial DPCD write.

Test Plan:
- Write then read: hpd_connect=1, write ADDR 0x00010 LEN 3 data A1 B2 C3 D4 -> reply 0x00. Read same -> 00 A1 B2 C3 D4, phy_start_stop high 5 cycles, first byte 6 cycles after aux_start_stop falls.
- Range check: read ADDR 0x000FE LEN 3 (DPCD_DEPTH=256) -> single byte 0x10. Write LEN 16 -> 0x10 and DPCD unchanged.
- Defer: defer_count=2, read ADDR 0 LEN 0 three times -> 0x20, 0x20, then 0x00 with data.
- Protocol errors: 2-byte request -> no reply, err_cnt=1. aux_start_stop held 3 cycles during WAIT -> err_cnt=4.
- HPD IRQ: hpd_connect=1 then hpd_irq_req pulse -> hpd_signal low exactly 500 cycles. Second req mid-pulse does not extend it.
- Disconnect/reset mid-burst: drop hpd_connect during TX of an 8-byte read -> aux_oe=0 next cycle, busy=0. Assert rst mid-write -> DPCD all 0, all outputs 0.
